catcore_cmd_dispatch: RTL

Parametrised UART command-frame dispatcher for the CatCore badge fabric, sitting between the UART core's RX frame output and TX trigger.
- Validates fixed-length frames and applies LED set/clear operations to an internal status register.
- Forwards payloads to NUM_CH downstream co-processor channels over ready/valid, with optional privilege gating.
- Queues response frames in a FIFO for transmission.
- Replaces ad-hoc per-command decoding with a generic, width/depth/channel-configurable block.

---
 rtl/catcore_pkg.sv | 26 ++
 rtl/catcore_resp_fifo.sv | 55 +++++
 rtl/catcore_cmd_dispatch.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/catcore_pkg.sv
// Shared command bytes, response status codes and dispatcher FSM states
// for the CatCore badge UART command path.
package catcore_pkg;

  localparam logic [7:0] CMD_LED      = 8'h41;  // "A"
  localparam logic [7:0] CMD_STATUS   = 8'h40;  // "@"
  localparam logic [7:0] CMD_CH_BASE  = 8'h30;  // "0"
  localparam logic [7:0] LED_ALL      = 8'h60;  // grave accent
  localparam logic [7:0] LED_SET_BASE = 8'h61;  // "a"

  localparam logic [7:0] STS_OK     = 8'h4B;  // "K"
  localparam logic [7:0] STS_DENIED = 8'h44;  // "D"
  localparam logic [7:0] STS_ERR    = 8'h45;  // "E"

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DISPATCH,
    ST_RESPOND
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/catcore_resp_fifo.sv
// Response frame FIFO; the head is shown combinationally and forced to zero
// while empty so the TX side never sees stale data.
module catcore_resp_fifo #(
  parameter int W     = 144,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         push_rdy,
  input  logic         pop,
  output logic         head_v,
  output logic [W-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic          empty, full, do_pop, do_push;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == FULL_CNT);
  assign do_pop   = pop & ~empty;
  // A pop frees the slot the simultaneous push lands in.
  assign push_rdy = ~full | do_pop;
  assign do_push  = push & push_rdy;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_v    = ~empty;
  assign head_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/catcore_cmd_dispatch.sv
// UART command-frame dispatcher: validates frames, drives the LED status
// register, forwards channel commands and queues response frames.
module catcore_cmd_dispatch
  import catcore_pkg::*;
#(
  parameter int         FRAME_BYTES = 18,
  parameter int         LED_WIDTH   = 8,
  parameter int         NUM_CH      = 4,
  parameter logic [7:0] PRIV_MASK   = 8'b0000_1000,
  parameter int         RESP_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic [FRAME_BYTES*8-1:0]    frame_i,
  input  logic                        frame_v_i,
  input  logic                        dev_unlock_i,
  output logic                        busy_o,
  output logic [NUM_CH-1:0]           ch_v_o,
  output logic [(FRAME_BYTES-2)*8-1:0] ch_payload_o,
  input  logic [NUM_CH-1:0]           ch_rdy_i,
  output logic                        tx_v_o,
  output logic [FRAME_BYTES*8-1:0]    tx_frame_o,
  input  logic                        tx_rdy_i,
  output logic [LED_WIDTH-1:0]        led_o,
  output logic [7:0]                  err_cnt_o,
  output logic [7:0]                  drop_cnt_o
);

  localparam int FW = FRAME_BYTES * 8;
  localparam int PW = (FRAME_BYTES - 2) * 8;

  state_t               state_reg;
  logic [FW-1:0]        frame_reg, resp_reg, resp_base, snap_bits;
  logic [LED_WIDTH-1:0] led_reg, led_next, clr_hit, set_hit;
  logic [NUM_CH-1:0]    ch_hit, ch_v_reg;
  logic [PW-1:0]        payload_reg;
  logic [7:0]           err_reg, drop_reg, cmd, arg, end_byte;
  logic                 is_ch, priv_block, ch_accept, push, push_rdy, pop;

  assign cmd      = frame_reg[7:0];
  assign arg      = frame_reg[15:8];
  assign end_byte = frame_reg[FW-1 -: 8];

  // Per-bit LED decode: "A"+i clears bit i, "a"+i sets bit i.
  generate
    for (genvar gi = 0; gi < LED_WIDTH; gi++) begin : g_led
      assign clr_hit[gi] = (arg == CMD_LED + 8'(gi));
      assign set_hit[gi] = (arg == LED_SET_BASE + 8'(gi));
    end
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_hit[gi] = (cmd == CMD_CH_BASE + 8'(gi));
    end
  endgenerate

  assign is_ch      = |ch_hit;
  assign priv_block = (|(ch_hit & PRIV_MASK[NUM_CH-1:0])) & ~dev_unlock_i;
  assign ch_accept  = |(ch_v_reg & ch_rdy_i);

  always_comb begin
    if (arg == LED_ALL) led_next = '1;
    else                led_next = (led_reg & ~clr_hit) | set_hit;
  end

  always_comb begin
    resp_base           = '0;
    resp_base[7:0]      = cmd;
    resp_base[FW-1 -: 8] = cmd;
  end

  always_comb begin
    snap_bits                  = '0;
    snap_bits[16 +: LED_WIDTH] = led_reg;
    snap_bits[31:24]           = err_reg;
    snap_bits[39:32]           = drop_reg;
  end

  function automatic logic [FW-1:0] with_status(input logic [FW-1:0] base,
                                                input logic [7:0]    st);
    with_status        = base;
    with_status[15:8]  = st;
  endfunction

  assign push = (state_reg == ST_RESPOND);
  assign pop  = tx_v_o & tx_rdy_i;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg   <= ST_IDLE;
      frame_reg   <= '0;
      resp_reg    <= '0;
      led_reg     <= '1;
      ch_v_reg    <= '0;
      payload_reg <= '0;
      err_reg     <= '0;
      drop_reg    <= '0;
    end else begin
      if (frame_v_i && state_reg != ST_IDLE) drop_reg <= sat_inc(drop_reg);
      case (state_reg)
        ST_IDLE: begin
          if (frame_v_i) begin
            frame_reg <= frame_i;
            state_reg <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (end_byte != cmd) begin
            err_reg   <= sat_inc(err_reg);
            state_reg <= ST_IDLE;
          end else if (cmd == CMD_LED) begin
            led_reg   <= led_next;
            resp_reg  <= with_status(resp_base, STS_OK);
            state_reg <= ST_RESPOND;
          end else if (cmd == CMD_STATUS) begin
            // Counters and LEDs are snapshotted here, not at push time.
            resp_reg  <= with_status(resp_base, STS_OK) | snap_bits;
            state_reg <= ST_RESPOND;
          end else if (is_ch && priv_block) begin
            resp_reg  <= with_status(resp_base, STS_DENIED);
            state_reg <= ST_RESPOND;
          end else if (is_ch) begin
            ch_v_reg    <= ch_hit;
            payload_reg <= frame_reg[FW-9:8];
            resp_reg    <= with_status(resp_base, STS_OK);
            state_reg   <= ST_DISPATCH;
          end else begin
            err_reg   <= sat_inc(err_reg);
            resp_reg  <= with_status(resp_base, STS_ERR);
            state_reg <= ST_RESPOND;
          end
        end
        ST_DISPATCH: begin
          if (ch_accept) begin
            ch_v_reg  <= '0;
            state_reg <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (push_rdy) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  catcore_resp_fifo #(
    .W     (FW),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .push      (push),
    .push_data (resp_reg),
    .push_rdy  (push_rdy),
    .pop       (pop),
    .head_v    (tx_v_o),
    .head_data (tx_frame_o)
  );

  assign busy_o       = (state_reg != ST_IDLE);
  assign ch_v_o       = ch_v_reg;
  assign ch_payload_o = payload_reg;
  assign led_o        = led_reg;
  assign err_cnt_o    = err_reg;
  assign drop_cnt_o   = drop_reg;

endmodule
